ms_timer_scheduler: RTL

Shares one millisecond time base among `N_CH` independent countdown timers used by the game/control logic. The block contains its own prescaler, which produces a one-cycle `tick` enable rather than a derived clock. Each tick, a sweep engine services every channel through a single shared decrementer, one channel per cycle. Client FSMs start, cancel and poll timers here instead of instantiating private clock dividers.

---
 rtl/timer_pkg.sv | 20 ++
 rtl/tick_prescaler.sv | 46 ++++
 rtl/ms_timer_scheduler.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the millisecond timer scheduler: sweep FSM states,
// default sizing constants and a select-width helper.
package timer_pkg;

    // Sweep engine states: waiting for a tick, or walking the channels.
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } sweep_state_e;

    localparam int TICK_DIV_1MS = 100000;
    localparam int TMR_CH       = 4;
    localparam int TMR_CW       = 16;

    // Width of a channel select; a single channel still gets one select bit.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running prescaler that emits a one-cycle tick enable every DIV cycles.
// Counter runs 0..DIV-1; tick is high while the counter holds DIV-1. The tick
// is registered, so it is produced one cycle early from the DIV-2 state.
module tick_prescaler
    import timer_pkg::*;
#(
    parameter int DIV = TICK_DIV_1MS
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [PW-1:0] cnt_q;
    logic [PW-1:0] cnt_d;
    logic          tick_q;
    logic          tick_d;

    // Next counter value with wrap, and the early tick decode.
    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (cnt_q == PW'(DIV - 1)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + PW'(1);
        end
        tick_d = (cnt_q == PW'(DIV - 2));
    end

    // Counter and tick registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/ms_timer_scheduler.sv
// Shared millisecond time base serving N_CH countdown timers. After each tick
// a sweep visits one channel per cycle and decrements it through a single
// shared decrementer. Start beats cancel and beats the sweep decrement.
module ms_timer_scheduler
    import timer_pkg::*;
#(
    parameter int DIV  = TICK_DIV_1MS,
    parameter int N_CH = TMR_CH,
    parameter int CW   = TMR_CW
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N_CH-1:0]                start,
    input  logic [N_CH*CW-1:0]             dur,
    input  logic [N_CH-1:0]                cancel,
    input  logic [sel_width(N_CH)-1:0]     rd_sel,
    output logic [N_CH-1:0]                busy,
    output logic [N_CH-1:0]                done,
    output logic                           tick,
    output logic [CW-1:0]                  rd_cnt
);

    localparam int SW = sel_width(N_CH);

    // The sweep must finish before the next tick arrives.
    generate
        if (DIV < N_CH + 2) begin : g_div_check
            $error("ms_timer_scheduler: DIV must be at least N_CH+2");
        end
    endgenerate

    sweep_state_e  state_q;
    sweep_state_e  state_d;
    logic [SW-1:0] idx_q;
    logic [SW-1:0] idx_d;
    logic [CW-1:0] count_q [N_CH];
    logic [CW-1:0] count_d [N_CH];
    logic [N_CH-1:0] active_q;
    logic [N_CH-1:0] active_d;
    logic [N_CH-1:0] done_q;
    logic [N_CH-1:0] done_d;
    logic [CW-1:0] dec_val;
    logic          dec_zero;
    logic          sweep_en;
    logic          tick_s;

    tick_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .tick (tick_s)
    );

    // Sweep FSM: leave IDLE on a tick, walk every channel index once.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (tick_s) begin
                    state_d = ST_SWEEP;
                    idx_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end
            end
            ST_SWEEP: begin
                if (idx_q == SW'(N_CH - 1)) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end else begin
                    state_d = ST_SWEEP;
                    idx_d   = idx_q + SW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Single shared decrementer fed by the channel currently being swept.
    always_comb begin
        sweep_en = (state_q == ST_SWEEP);
        dec_val  = count_q[idx_q] - CW'(1);
        dec_zero = (dec_val == '0);
    end

    // Per-channel update: start, then cancel, then sweep decrement, else hold.
    always_comb begin
        count_d  = count_q;
        active_d = active_q;
        done_d   = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (start[i]) begin
                count_d[i]  = dur[i*CW +: CW];
                active_d[i] = (dur[i*CW +: CW] != '0);
                done_d[i]   = (dur[i*CW +: CW] == '0);
            end else if (cancel[i]) begin
                count_d[i]  = '0;
                active_d[i] = 1'b0;
                done_d[i]   = 1'b0;
            end else if (sweep_en && (idx_q == SW'(i)) && active_q[i]) begin
                count_d[i] = dec_val;
                if (dec_zero) begin
                    active_d[i] = 1'b0;
                    done_d[i]   = 1'b1;
                end else begin
                    active_d[i] = 1'b1;
                    done_d[i]   = 1'b0;
                end
            end else begin
                count_d[i]  = count_q[i];
                active_d[i] = active_q[i];
                done_d[i]   = 1'b0;
            end
        end
    end

    // State, index, counts, active bits and done pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            active_q <= '0;
            done_q   <= '0;
            for (int i = 0; i < N_CH; i++) begin
                count_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            active_q <= active_d;
            done_q   <= done_d;
            count_q  <= count_d;
        end
    end

    // Read port is a plain mux of the count registers.
    always_comb begin
        rd_cnt = count_q[rd_sel];
    end

    assign busy = active_q;
    assign done = done_q;
    assign tick = tick_s;

endmodule
